// File: rtl/selftrigger_frame_capture.sv
// Self-triggered frame capture: keeps a rolling pre-trigger history in a
// sample RAM, records the post-trigger tail, then streams a 4-word header
// plus FRAME_LEN samples over a valid/ready port.
module selftrigger_frame_capture #(
  parameter int PRE_DEPTH = 64,
  parameter int FRAME_LEN = 256
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic signed [15:0] x,
  input  logic               trigger,
  input  logic [47:0]        timestamp,
  input  logic [7:0]         channel_id,
  output logic [15:0]        dout,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               busy,
  output logic [15:0]        missed_count
);

  localparam int AW          = $clog2(FRAME_LEN);
  localparam int POST_LEN    = FRAME_LEN - PRE_DEPTH;
  localparam int FRAME_WORDS = FRAME_LEN + 4;
  localparam int OW          = $clog2(FRAME_WORDS + 1);

  localparam logic [AW-1:0] PRE_M1    = AW'(PRE_DEPTH - 1);
  localparam logic [AW-1:0] PRE_A     = AW'(PRE_DEPTH);
  localparam logic [AW-1:0] POST_M1   = AW'(POST_LEN - 1);
  localparam logic [OW-1:0] WORDS     = OW'(FRAME_WORDS);
  localparam logic [OW-1:0] LAST_IDX  = OW'(FRAME_WORDS - 1);
  localparam logic [OW-1:0] HDR_LAST  = OW'(3);
  localparam logic [OW-1:0] HDR_WORDS = OW'(4);

  typedef enum logic [2:0] {FILL, ARMED, POST, HEADER, DATA} state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem [FRAME_LEN];
  logic [15:0]     ram_q;      // prefetch register: always holds mem[rd_ptr]
  logic [AW-1:0]   wr_ptr, trig_ptr, rd_ptr, rd_ptr_d;
  logic [AW-1:0]   fill_cnt, post_cnt;
  logic [OW-1:0]   out_cnt;    // words loaded into the output register
  logic [47:0]     ts_lat;
  logic [15:0]     word_mux;
  logic            hit, wr_en, emitting, out_load, out_more;

  assign hit      = enable && trigger;
  assign wr_en    = enable && (state_q == FILL || state_q == ARMED || state_q == POST);
  assign emitting = (state_q == HEADER || state_q == DATA);
  // Output register may take a new word when empty or being drained.
  assign out_load = emitting && (!dout_valid || dout_ready);
  assign out_more = out_cnt < WORDS;
  assign busy     = (state_q != ARMED);

  // Next state and read-address prefetch; the RAM reads the *next* pointer so
  // ram_q already holds the upcoming data word when it is needed.
  always_comb begin
    state_d  = state_q;
    rd_ptr_d = rd_ptr;
    case (state_q)
      FILL:    if (enable && fill_cnt == PRE_M1) state_d = ARMED;
      ARMED:   if (hit) state_d = (POST_LEN == 1) ? HEADER : POST;
      POST:    if (enable && post_cnt == POST_M1) state_d = HEADER;
      HEADER:  if (out_load && out_cnt == HDR_LAST) state_d = DATA;
      DATA:    if (dout_valid && dout_ready && dout_last) state_d = FILL;
      default: state_d = FILL;
    endcase
    if (state_d == HEADER && state_q != HEADER)
      rd_ptr_d = ((state_q == ARMED) ? wr_ptr : trig_ptr) - PRE_A;
    else if (out_load && out_more && out_cnt >= HDR_WORDS)
      rd_ptr_d = rd_ptr + AW'(1);
  end

  // Header words come from live/latched inputs, data words from the prefetch.
  always_comb begin
    case (out_cnt)
      OW'(0):  word_mux = {8'hA5, channel_id};
      OW'(1):  word_mux = ts_lat[47:32];
      OW'(2):  word_mux = ts_lat[31:16];
      OW'(3):  word_mux = ts_lat[15:0];
      default: word_mux = ram_q;
    endcase
  end

  // Sample RAM and its registered read port; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= x;
    ram_q <= mem[rd_ptr_d];
  end

  // State, write-side pointers and capture counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= FILL;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      trig_ptr <= '0;
      fill_cnt <= '0;
      post_cnt <= '0;
      ts_lat   <= '0;
    end else begin
      state_q <= state_d;
      rd_ptr  <= rd_ptr_d;
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      // Cleared outside FILL so every return to FILL rebuilds full history.
      if (state_q == FILL) begin
        if (enable) fill_cnt <= fill_cnt + AW'(1);
      end else begin
        fill_cnt <= '0;
      end
      if (state_q == ARMED && hit) begin
        trig_ptr <= wr_ptr;
        ts_lat   <= timestamp;
        post_cnt <= AW'(1);          // trigger sample counts toward the tail
      end else if (state_q == POST && enable) begin
        post_cnt <= post_cnt + AW'(1);
      end
    end
  end

  // Output register: loads one word per accepted slot, holds while stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      out_cnt    <= '0;
    end else if (!emitting) begin
      dout_valid <= 1'b0;
      dout_last  <= 1'b0;
      out_cnt    <= '0;
    end else if (out_load) begin
      if (out_more) begin
        dout       <= word_mux;
        dout_valid <= 1'b1;
        dout_last  <= (out_cnt == LAST_IDX);
        out_cnt    <= out_cnt + OW'(1);
      end else begin
        dout_valid <= 1'b0;
        dout_last  <= 1'b0;
      end
    end
  end

  // Saturating count of qualified triggers that arrive while not armed.
  always_ff @(posedge clk) begin
    if (reset)
      missed_count <= '0;
    else if (hit && state_q != ARMED && missed_count != 16'hFFFF)
      missed_count <= missed_count + 16'd1;
  end

endmodule

// File: tb/tb_selftrigger_frame_capture.sv
// Bench for selftrigger_frame_capture: sample-history reference model plus
// directed scenarios and a randomized soak.
module tb_selftrigger_frame_capture;
  localparam int PRE  = 64;
  localparam int FL   = 256;
  localparam int POST = FL - PRE;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, enable, trigger, dout_ready;
  logic signed [15:0] x;
  logic [47:0]        timestamp;
  logic [7:0]         channel_id;
  logic [15:0]        dout, missed_count;
  logic               dout_valid, dout_last, busy;

  selftrigger_frame_capture #(.PRE_DEPTH(PRE), .FRAME_LEN(FL)) dut (
    .clk(clk), .reset(reset), .enable(enable), .x(x), .trigger(trigger),
    .timestamp(timestamp), .channel_id(channel_id), .dout(dout),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_last(dout_last),
    .busy(busy), .missed_count(missed_count)
  );

  int checks = 0;
  int failures = 0;

  function automatic void chk(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endfunction

  // Reference model: the frame is simply "PRE samples before the trigger,
  // the trigger sample and POST-1 after it", taken from the list of samples
  // accepted since the last rebuild.
  typedef struct { logic [15:0] w; logic last; } word_t;
  word_t       exp_q[$];
  logic [15:0] hist[$];
  logic [15:0] rx_q[$], ref_q[$];
  int          phase, trig_idx, pcnt, frames_done;
  logic [15:0] m_missed;
  logic [47:0] m_ts, ts_cnt;
  logic        prev_v, prev_rdy;
  int          scnt, cyc, en_mode, rdy_mode, x_rand, trig_rand;
  int          trig_list[4];

  function automatic void model_reset();
    phase = 0; hist.delete(); exp_q.delete(); m_missed = 16'd0;
  endfunction

  function automatic void build_frame();
    word_t wd;
    wd.last = 1'b0;
    wd.w = {8'hA5, channel_id}; exp_q.push_back(wd);
    wd.w = m_ts[47:32];         exp_q.push_back(wd);
    wd.w = m_ts[31:16];         exp_q.push_back(wd);
    wd.w = m_ts[15:0];          exp_q.push_back(wd);
    for (int k = 0; k < FL; k++) begin
      wd.w = hist[trig_idx - PRE + k];
      wd.last = (k == FL - 1);
      exp_q.push_back(wd);
    end
  endfunction

  function automatic void model_step(logic en, logic trg, logic [15:0] xv, logic xfer);
    logic  armed;
    word_t wd;
    armed = (phase == 0 && hist.size() >= PRE);
    if (en && trg && !armed && m_missed != 16'hFFFF) m_missed++;
    if (en && phase == 0) begin
      if (armed && trg) begin
        trig_idx = hist.size(); m_ts = ts_cnt; pcnt = 1; phase = 1;
      end
      hist.push_back(xv);
    end else if (en && phase == 1) begin
      hist.push_back(xv); pcnt++;
    end
    if (phase == 1 && pcnt == POST) begin
      build_frame(); phase = 2;
    end
    if (xfer && exp_q.size() > 0) begin
      wd = exp_q.pop_front();
      if (wd.last) begin
        phase = 0; hist.delete(); frames_done++;
      end
    end
  endfunction

  // Compare process: DUT outputs against the model after every edge.
  task automatic check();
    chk("busy", longint'(busy), (phase == 0 && hist.size() >= PRE) ? 0 : 1);
    chk("missed_count", longint'(missed_count), longint'(m_missed));
    if (phase != 2) chk("valid_outside_readout", longint'(dout_valid), 0);
    if (dout_valid) begin
      chk("word_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        chk("dout", longint'(dout), longint'(exp_q[0].w));
        chk("dout_last", longint'(dout_last), longint'(exp_q[0].last));
      end
    end
    if (prev_v && !prev_rdy) chk("hold_valid", longint'(dout_valid), 1);
  endtask

  task automatic step(input logic rst, input logic en, input logic trg,
                      input logic [15:0] xv, input logic rdy);
    logic xfer;
    reset = rst; enable = en; trigger = trg; x = xv; dout_ready = rdy;
    timestamp = ts_cnt;
    if (rst) begin
      model_reset(); rx_q.delete(); prev_v = 1'b0; prev_rdy = 1'b1;
    end else begin
      xfer = dout_valid && rdy;
      if (xfer) rx_q.push_back(dout);
      model_step(en, trg, xv, xfer);
      prev_v = dout_valid; prev_rdy = rdy;
    end
    @(posedge clk);
    ts_cnt++;
    @(negedge clk);
    check();
  endtask

  task automatic gen_cycle();
    logic en, trg, rdy;
    logic [15:0] xv;
    case (en_mode)
      0:       en = 1'b1;
      1:       en = (cyc % 3 == 0);
      default: en = ($urandom_range(3) != 0);
    endcase
    xv = x_rand ? 16'($urandom) : 16'(scnt);
    trg = 1'b0;
    for (int i = 0; i < 4; i++) if (en && trig_list[i] == scnt) trg = 1'b1;
    if (trig_rand != 0) trg = ($urandom_range(39) == 0);
    rdy = (rdy_mode != 0) ? 1'($urandom_range(1)) : 1'b1;
    step(1'b0, en, trg, xv, rdy);
    if (en) scnt++;
    cyc++;
  endtask

  task automatic start_test(input int em, input int rm, input int xr, input int tr,
                            input int t0, input int t1, input int t2);
    en_mode = em; rdy_mode = rm; x_rand = xr; trig_rand = tr;
    trig_list = '{t0, t1, t2, -1};
    scnt = 0; cyc = 0; ts_cnt = 48'hABCD_0000_0000;
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
    step(1'b1, 1'b0, 1'b0, 16'h0, 1'b1);
  endtask

  task automatic run_frames(input int n, input int budget, input string name);
    int f0, k;
    f0 = frames_done; k = 0;
    while (frames_done < f0 + n && k < budget) begin
      gen_cycle(); k++;
    end
    chk(name, longint'(frames_done - f0), longint'(n));
  endtask

  initial begin
    int k, f0, bad;
    channel_id = 8'h3C; frames_done = 0; prev_v = 1'b0; prev_rdy = 1'b1;
    reset = 1'b1; enable = 1'b0; trigger = 1'b0; x = '0; dout_ready = 1'b1;
    timestamp = '0; ts_cnt = '0;
    model_reset();

    // Ramp, trigger at sample 100, no back-pressure.
    start_test(0, 0, 0, 0, 100, -1, -1);
    chk("rst_dout", longint'(dout), 0);
    chk("rst_valid", longint'(dout_valid), 0);
    chk("rst_last", longint'(dout_last), 0);
    chk("rst_busy", longint'(busy), 1);
    chk("rst_missed", longint'(missed_count), 0);
    run_frames(1, 2000, "t1_frame_done");
    chk("t1_len", longint'(rx_q.size()), 260);
    chk("t1_hdr0", longint'(rx_q[0]), longint'(16'hA53C));
    chk("t1_ts_hi", longint'(rx_q[1]), longint'(16'hABCD));
    chk("t1_first_data", longint'(rx_q[4]), 36);
    chk("t1_trig_sample", longint'(rx_q[68]), 100);
    chk("t1_last_data", longint'(rx_q[259]), 291);
    ref_q = rx_q;
    k = 0;
    while (busy && k < 300) begin gen_cycle(); k++; end
    chk("t1_rearm_samples", longint'(k), 64);

    // Trigger while still filling.
    start_test(0, 0, 0, 0, 10, -1, -1);
    repeat (20) gen_cycle();
    chk("t2_missed", longint'(missed_count), 1);
    chk("t2_busy", longint'(busy), 1);

    // Extra triggers during POST and DATA are dropped.
    start_test(0, 0, 0, 0, 100, 150, 350);
    f0 = frames_done;
    run_frames(1, 2000, "t3_frame_done");
    repeat (100) gen_cycle();
    chk("t3_missed", longint'(missed_count), 2);
    chk("t3_frames", longint'(frames_done - f0), 1);

    // Random back-pressure gives the same data as the free-running readout.
    start_test(0, 1, 0, 0, 100, -1, -1);
    run_frames(1, 4000, "t4_frame_done");
    chk("t4_len", longint'(rx_q.size()), 260);
    bad = 0;
    for (int i = 4; i < 260; i++) if (rx_q[i] != ref_q[i]) bad++;
    chk("t4_same_as_free", longint'(bad), 0);

    // Sparse enable with the frame wrapping the RAM address.
    start_test(1, 0, 0, 0, 150, -1, -1);
    run_frames(1, 3000, "t5_frame_done");
    chk("t5_first_data", longint'(rx_q[4]), 86);
    bad = 0;
    for (int i = 5; i < 260; i++) if (rx_q[i] != 16'(rx_q[i-1] + 16'd1)) bad++;
    chk("t5_contiguous", longint'(bad), 0);

    // Reset in the middle of DATA, then a fresh capture.
    start_test(0, 0, 0, 0, 100, -1, -1);
    k = 0;
    while (rx_q.size() < 54 && k < 2000) begin gen_cycle(); k++; end
    chk("t6_reach_word50", longint'(rx_q.size()), 54);
    step(1'b1, 1'b1, 1'b0, 16'(scnt), 1'b1);
    chk("t6_valid_after_rst", longint'(dout_valid), 0);
    chk("t6_missed_after_rst", longint'(missed_count), 0);
    scnt = 0; trig_list = '{64, -1, -1, -1};
    run_frames(1, 2000, "t6_frame_done");
    chk("t6_len", longint'(rx_q.size()), 260);
    chk("t6_first_data", longint'(rx_q[4]), 0);
    chk("t6_trig_sample", longint'(rx_q[68]), 64);
    chk("t6_last_data", longint'(rx_q[259]), 255);

    // Randomized soak: random data, enable, trigger and ready.
    start_test(2, 1, 1, 1, -1, -1, -1);
    f0 = frames_done;
    repeat (5000) gen_cycle();
    chk("t7_frames_seen", longint'(frames_done > f0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
